// File: rtl/sa_seq_ctrl_pkg.sv
// sa_seq_ctrl_pkg: shared systolic-array configuration
package sa_seq_ctrl_pkg;
  localparam int ARRAYHEIGHT = 4;
  localparam int ARRAYWIDTH = 4;
  localparam int DSP_DELAY = 2;
  localparam int DATASIZE = 8;
  localparam int OUTPUT_BUF_DATASIZE = 16;
endpackage

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: job sequencer for weight load, activation load, fill, output capture and drain
module sa_seq_ctrl
  import sa_seq_ctrl_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_data,
  output logic                                      weight_buffer_load_en,
  output logic                                      weight_buffer_out_en,
  output logic                                      write_weight_en,
  output logic                                      input_buffer_load_en,
  output logic                                      input_buffer_out_en,
  output logic                                      output_buffer_load_en,
  output logic                                      output_buffer_out_en,
  output logic [DATASIZE*ARRAYWIDTH-1:0]            in_weight,
  output logic [DATASIZE*ARRAYWIDTH-1:0]            in_act,
  input  logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_res
);
  localparam int H = ARRAYHEIGHT;
  localparam int W = ARRAYWIDTH;
  localparam int D = DSP_DELAY;
  localparam int FILL_LEN = D * (W - 1);
  localparam int OLOAD_LEN = 2 * H * D;
  localparam int CW = $clog2(OLOAD_LEN + 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(H - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(FILL_LEN > 0 ? FILL_LEN - 1 : 0);
  localparam logic [CW-1:0] OLOAD_LAST = CW'(OLOAD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    ALOAD = 3'd2,
    FILL  = 3'd3,
    OLOAD = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_e;

  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic row_last;

  assign row_last = cnt_q == ROW_LAST;

  // Phase sequencing: counter advances only on accepted rows, fixed-length phase cycles, or drain beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= WLOAD;
          cnt_q <= '0;
        end
        WLOAD: if (in_valid) begin
          cnt_q <= row_last ? '0 : cnt_q + 1'b1;
          if (row_last) state_q <= ALOAD;
        end
        ALOAD: if (in_valid) begin
          cnt_q <= row_last ? '0 : cnt_q + 1'b1;
          if (row_last) state_q <= (W > 1) ? FILL : OLOAD;
        end
        FILL: begin
          cnt_q <= (cnt_q == FILL_LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == FILL_LAST) state_q <= OLOAD;
        end
        OLOAD: begin
          cnt_q <= (cnt_q == OLOAD_LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == OLOAD_LAST) state_q <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          cnt_q <= row_last ? '0 : cnt_q + 1'b1;
          if (row_last) state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign in_ready = (state_q == WLOAD) || (state_q == ALOAD);
  assign weight_buffer_load_en = (state_q == WLOAD) && in_valid;
  assign input_buffer_load_en = (state_q == ALOAD) && in_valid;
  assign write_weight_en = input_buffer_load_en;
  assign weight_buffer_out_en = input_buffer_load_en;
  assign input_buffer_out_en = (state_q == FILL) || (state_q == OLOAD);
  assign output_buffer_load_en = state_q == OLOAD;
  assign output_buffer_out_en = (state_q == DRAIN) && out_ready;
  assign out_valid = output_buffer_out_en;
  assign in_weight = weight_buffer_load_en ? in_data : '0;
  assign in_act = input_buffer_load_en ? in_data : '0;
  assign out_data = (state_q == DRAIN) ? out_res : '0;
endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: directed cycle-accurate checks of the sequencer for H=W=4, D=2
module tb_sa_seq_ctrl;
  import sa_seq_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic busy, done, in_ready, out_valid;
  logic [DATASIZE*ARRAYWIDTH-1:0] in_data, in_weight, in_act;
  logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_data, out_res;
  logic wle, wbo, wwe, ile, ibo, obl, obo;
  logic [63:0] res_rows [4];
  int tests = 0;
  int fails = 0;

  sa_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .weight_buffer_load_en(wle), .weight_buffer_out_en(wbo), .write_weight_en(wwe),
    .input_buffer_load_en(ile), .input_buffer_out_en(ibo),
    .output_buffer_load_en(obl), .output_buffer_out_en(obo),
    .in_weight(in_weight), .in_act(in_act), .out_res(out_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, in_ready, out_valid, wle, wbo, wwe, ile, ibo, obl, obo}), 64'd0);
    chk({tag, "_wgt"}, 64'(in_weight), 64'd0);
    chk({tag, "_act"}, 64'(in_act), 64'd0);
    chk({tag, "_out"}, out_data, 64'd0);
  endtask

  // One job from start at cycle 0; wstall/astall are cycles with in_valid low, gap is the
  // out_ready-low stretch after the first beat, abort_at returns early at that cycle.
  task automatic run_job(input int wstall, input int astall, input int gap, input int abort_at, input int exp_done);
    int w_end, a_end, d0, dend, done_c, beat, seen_done;
    logic e_wl, e_al, e_inr, e_ibo, e_obl, e_drn, e_ob, e_bsy, e_dn;
    w_end = 4 + (wstall > 0 ? 1 : 0);
    a_end = w_end + 4 + (astall > 0 ? 1 : 0);
    d0 = a_end + 23;
    dend = d0 + 3 + gap;
    done_c = dend + 1;
    beat = 0;
    seen_done = -1;
    for (int c = 0; c <= done_c + 1; c++) begin
      if (c == abort_at) return;
      start = (c == 0) || (c == a_end + 2) || (c == done_c);
      in_valid = !(c == wstall || c == astall);
      out_ready = !(gap > 0 && c > d0 && c <= d0 + gap);
      in_data = $urandom;
      out_res = (beat < 4) ? res_rows[beat] : 64'h0;
      #1;
      e_wl = c >= 1 && c <= w_end && c != wstall;
      e_al = c > w_end && c <= a_end && c != astall;
      e_inr = c >= 1 && c <= a_end;
      e_ibo = c > a_end && c <= a_end + 22;
      e_obl = c > a_end + 6 && c <= a_end + 22;
      e_drn = c >= d0 && c <= dend;
      e_ob = e_drn && out_ready;
      e_bsy = c >= 1 && c <= done_c;
      e_dn = c == done_c;
      chk($sformatf("ctl@%0d", c),
          64'({busy, done, in_ready, out_valid, wle, wbo, wwe, ile, ibo, obl, obo}),
          64'({e_bsy, e_dn, e_inr, e_ob, e_wl, e_al, e_al, e_al, e_ibo, e_obl, e_ob}));
      chk($sformatf("in_weight@%0d", c), 64'(in_weight), e_wl ? 64'(in_data) : 64'd0);
      chk($sformatf("in_act@%0d", c), 64'(in_act), e_al ? 64'(in_data) : 64'd0);
      chk($sformatf("out_data@%0d", c), out_data, e_drn ? out_res : 64'd0);
      if (done) seen_done = c;
      if (obo) begin
        chk($sformatf("row%0d", beat), out_data, (beat < 4) ? res_rows[beat] : 64'hdead);
        beat++;
      end
      @(posedge clk);
      #1;
    end
    chk("done_cycle", 64'(seen_done), 64'(exp_done));
    chk("beat_count", 64'(beat), 64'd4);
  endtask

  initial begin
    res_rows[0] = 64'h0001_0002_0003_0004;
    res_rows[1] = 64'h0010_0020_0030_0040;
    res_rows[2] = 64'h0100_0200_0300_0400;
    res_rows[3] = 64'h1000_2000_3000_4000;
    rst = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 32'hA5A5_5A5A;
    out_res = 64'hFFFF_0000_FFFF_0000;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    start = 1'b0;
    run_job(-1, -1, 0, -1, 35);
    run_job(2, 8, 0, -1, 37);
    run_job(-1, -1, 3, -1, 38);
    run_job(-1, -1, 0, 20, -1);
    in_valid = 1'b1;
    out_ready = 1'b1;
    out_res = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_done", 64'(done), 64'd0);
    end
    rst = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", 64'({busy, done, obl, obo}), 64'd0);
    end
    run_job(-1, -1, 0, -1, 35);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
